// File: rtl/rr_arbiter_4_if.sv
// ============================================================================
// Module      : rr_arbiter_4_if
// Description : Request/grant bundle between requesters and rr_arbiter_4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arbiter_4_if;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;

    modport master (
        output req,
        output done,
        input  sel,
        input  grant,
        input  valid
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output grant,
        output valid
    );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter_4.sv
// ============================================================================
// Module      : rr_arbiter_4
// Description : 4-channel round-robin arbiter with registered one-hot grant,
//               binary mux select and optional hold timeout
//               (macro RR_ARBITER_4_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_4 #(
    parameter int MAX_HOLD = 15
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    rr_arbiter_4_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 16) begin : g_bad_max_hold
            $error("rr_arbiter_4: MAX_HOLD must be in 1..16");
        end
    endgenerate

    // First requesting channel when searching upward from p, wrapping mod 4.
    function automatic logic [1:0] f_pick(input logic [3:0] req, input logic [1:0] p);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_sel;
    logic [3:0] r_grant;
    logic       r_valid;

    logic [1:0] w_pick_idle;
    logic [1:0] w_next_ptr;
    logic [1:0] w_pick_next;
    logic       w_any_req;
    logic       w_timeout;
    logic       w_release;

`ifdef RR_ARBITER_4_TIMEOUT_EN
    localparam logic [3:0] c_HOLD_LAST = 4'(MAX_HOLD - 1);
    logic [3:0] r_hold;
    assign w_timeout = (r_hold == c_HOLD_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_any_req   = |bus.req;
    assign w_pick_idle = f_pick(bus.req, r_ptr);
    assign w_next_ptr  = r_sel + 2'd1;
    assign w_pick_next = f_pick(bus.req, w_next_ptr);
    assign w_release   = bus.done | ~bus.req[r_sel] | w_timeout;

    // Release and re-arbitration happen on the same edge so back-to-back
    // requesters see no idle bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_grant <= 4'd0;
            r_valid <= 1'b0;
`ifdef RR_ARBITER_4_TIMEOUT_EN
            r_hold  <= 4'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_GRANT;
                        r_sel   <= w_pick_idle;
                        r_grant <= f_onehot(w_pick_idle);
                        r_valid <= 1'b1;
`ifdef RR_ARBITER_4_TIMEOUT_EN
                        r_hold  <= 4'd0;
`endif
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_ptr <= w_next_ptr;
                        if (w_any_req) begin
                            r_sel   <= w_pick_next;
                            r_grant <= f_onehot(w_pick_next);
`ifdef RR_ARBITER_4_TIMEOUT_EN
                            r_hold  <= 4'd0;
`endif
                        end else begin
                            r_state <= S_IDLE;
                            r_grant <= 4'd0;
                            r_valid <= 1'b0;
                        end
                    end
`ifdef RR_ARBITER_4_TIMEOUT_EN
                    else begin
                        r_hold <= r_hold + 4'd1;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 4'd0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel   = r_sel;
    assign bus.grant = r_grant;
    assign bus.valid = r_valid;

endmodule

`default_nettype wire
